switch_input: RTL

Memory-mapped input peripheral that lets the CPU read the 24 board slide switches through the MMIO bus; it is the read-side counterpart of the LED output port. Raw switch levels are synchronized, debounced as a group, and exposed as a stable value plus sticky per-bit change flags. The change flags clear on read. Read data is registered, so it arrives one cycle after the select/read strobe.

---
 rtl/switch_input.sv | 103 ++++++++++
 1 files changed

// File: rtl/switch_input.sv
// MMIO slide-switch input port: two-flop synchronizer, whole-vector debounce,
// sticky read-to-clear change flags and a registered 16-bit read port.
module switch_input #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        switch_clk,
    input  logic        switchrst,
    input  logic        switchread,
    input  logic        switchcs,
    input  logic [1:0]  switchaddr,
    input  logic [23:0] switch_i,
    output logic [15:0] switchrdata,
    output logic [23:0] switchval
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ADDR_VAL_LO  = 2'b00,
        ADDR_FLAG_LO = 2'b01,
        ADDR_VAL_HI  = 2'b10,
        ADDR_FLAG_HI = 2'b11
    } addr_e;

    logic [23:0]      sync1_q, sync1_d;
    logic [23:0]      sync2_q, sync2_d;
    logic [23:0]      candidate_q, candidate_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [23:0]      debounced_q, debounced_d;
    logic [23:0]      flags_q, flags_d;
    logic [15:0]      rdata_q, rdata_d;
    logic [23:0]      set_mask;
    logic [23:0]      clr_mask;

    // NOTE: every always_comb output gets a default first, so no path can leave
    // a signal unassigned and infer a latch.
    always_comb begin
        sync1_d     = switch_i;
        sync2_d     = sync1_q;
        candidate_d = candidate_q;
        counter_d   = counter_q;
        debounced_d = debounced_q;
        rdata_d     = rdata_q;
        set_mask    = '0;
        clr_mask    = '0;

        // Any difference from the candidate restarts the count for the whole vector.
        if (sync2_q != candidate_q) begin
            candidate_d = sync2_q;
            counter_d   = '0;
        end else if (counter_q < CNT_LAST) begin
            counter_d = counter_q + 1'b1;
        end else begin
            debounced_d = candidate_q;
            set_mask    = debounced_q ^ candidate_q;
        end

        if (switchcs && switchread) begin
            case (addr_e'(switchaddr))
                ADDR_VAL_LO:  rdata_d = debounced_q[15:0];
                ADDR_VAL_HI:  rdata_d = {8'h00, debounced_q[23:16]};
                ADDR_FLAG_LO: begin
                    rdata_d  = flags_q[15:0];
                    clr_mask = 24'h00_FFFF;
                end
                ADDR_FLAG_HI: begin
                    rdata_d  = {8'h00, flags_q[23:16]};
                    clr_mask = 24'hFF_0000;
                end
            endcase
        end

        // Set wins over a same-edge clear so no change event is ever lost.
        flags_d = (flags_q & ~clr_mask) | set_mask;
    end

    // NOTE: state is updated with non-blocking assignments so every flop sees
    // the pre-edge values of the others, matching the hardware.
    always_ff @(posedge switch_clk) begin
        if (switchrst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            candidate_q <= '0;
            counter_q   <= '0;
            debounced_q <= '0;
            flags_q     <= '0;
            rdata_q     <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            candidate_q <= candidate_d;
            counter_q   <= counter_d;
            debounced_q <= debounced_d;
            flags_q     <= flags_d;
            rdata_q     <= rdata_d;
        end
    end

    assign switchrdata = rdata_q;
    assign switchval   = debounced_q;

endmodule
